// File: rtl/cp0_exception_unit_if.sv
// Core-side bundle between the instruction decoder/fetch stage and the CP0 responder.
interface cp0_exception_unit_if #(
    parameter int NIRQ = 3
);
    logic            in_valid;
    logic [31:0]     in_pc;
    logic            in_syscall;
    logic            in_eret;
    logic            in_cp0;
    logic            in_cpw;
    logic [4:0]      in_sel;
    logic [31:0]     in_wdata;
    logic [NIRQ-1:0] in_irq;
    logic [31:0]     out_rdata;
    logic            out_redirect;
    logic [31:0]     out_target;
    logic            out_busy;
    logic [31:0]     out_status;
    logic [31:0]     out_cause;
    logic [31:0]     out_epc;

    modport master (
        output in_valid, in_pc, in_syscall, in_eret, in_cp0, in_cpw, in_sel, in_wdata, in_irq,
        input  out_rdata, out_redirect, out_target, out_busy, out_status, out_cause, out_epc
    );

    modport slave (
        input  in_valid, in_pc, in_syscall, in_eret, in_cp0, in_cpw, in_sel, in_wdata, in_irq,
        output out_rdata, out_redirect, out_target, out_busy, out_status, out_cause, out_epc
    );
endinterface

// File: rtl/cp0_exception_unit.sv
// CP0 Status/Cause/EPC registers, IRQ edge capture and exception entry/return sequencing.
//   state  | meaning
//   IDLE   | accepting retiring instructions and CP0 strobes
//   ENTER  | redirect to the handler, CPU stalled
//   RETURN | redirect to EPC, CPU stalled
module cp0_exception_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0800,
    parameter int          NIRQ         = 3
) (
    input logic                 in_clk,
    input logic                 in_rst_n,
    cp0_exception_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        RETURN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            ie_q, ie_d;
    logic [NIRQ-1:0] im_q, im_d;
    logic [NIRQ-1:0] ip_q, ip_d;
    logic [4:0]      exc_q, exc_d;
    logic [31:0]     epc_q, epc_d;
    logic [NIRQ-1:0] irq_prev_q;
    logic            redirect_q, redirect_d;
    logic            busy_q, busy_d;
    logic [31:0]     target_q, target_d;

    logic [NIRQ-1:0] irq_rise;
    logic [NIRQ-1:0] pend;
    logic [NIRQ-1:0] lowest;
    logic            int_req;
    logic [31:0]     status_w;
    logic [31:0]     cause_w;

    assign irq_rise = bus.in_irq & ~irq_prev_q;
    assign pend     = ip_q & im_q;
    assign int_req  = ie_q & (|pend);

    // Descending scan: the last hit is the lowest pending line.
    always_comb begin
        lowest = '0;
        for (int k = NIRQ - 1; k >= 0; k--) begin
            if (pend[k]) begin
                lowest    = '0;
                lowest[k] = 1'b1;
            end
        end
    end

    always_comb begin
        status_w           = '0;
        status_w[0]        = ie_q;
        status_w[8 +: NIRQ] = im_q;
        cause_w            = '0;
        cause_w[6:2]       = exc_q;
        cause_w[8 +: NIRQ] = ip_q;
    end

    always_comb begin
        bus.out_rdata = '0;
        if (bus.in_cp0) begin
            case (bus.in_sel)
                5'd12:   bus.out_rdata = status_w;
                5'd13:   bus.out_rdata = cause_w;
                5'd14:   bus.out_rdata = epc_q;
                default: bus.out_rdata = '0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        ie_d       = ie_q;
        im_d       = im_q;
        ip_d       = ip_q;
        exc_d      = exc_q;
        epc_d      = epc_q;
        redirect_d = 1'b0;
        busy_d     = 1'b0;
        target_d   = target_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_cpw) begin
                    case (bus.in_sel)
                        5'd12: begin
                            ie_d = bus.in_wdata[0];
                            im_d = bus.in_wdata[8 +: NIRQ];
                        end
                        5'd13:   ip_d  = bus.in_wdata[8 +: NIRQ];
                        5'd14:   epc_d = bus.in_wdata;
                        default: ;
                    endcase
                end
                if (bus.in_valid && bus.in_syscall) begin
                    epc_d   = bus.in_pc;
                    exc_d   = 5'd8;
                    ie_d    = 1'b0;
                    state_d = ENTER;
                end else if (bus.in_valid && bus.in_eret) begin
                    ie_d    = 1'b1;
                    state_d = RETURN;
                end else if (bus.in_valid && int_req && !bus.in_cpw) begin
                    epc_d   = bus.in_pc + 32'd4;
                    exc_d   = 5'd0;
                    ie_d    = 1'b0;
                    ip_d    = ip_q & ~lowest;
                    state_d = ENTER;
                end
            end
            ENTER:   state_d = IDLE;
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Edge capture is applied last so a new request beats a software clear.
        ip_d = ip_d | irq_rise;

        if (state_d == ENTER) begin
            redirect_d = 1'b1;
            busy_d     = 1'b1;
            target_d   = HANDLER_ADDR;
        end else if (state_d == RETURN) begin
            redirect_d = 1'b1;
            busy_d     = 1'b1;
            target_d   = epc_q;
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q    <= IDLE;
            ie_q       <= 1'b0;
            im_q       <= '0;
            ip_q       <= '0;
            exc_q      <= '0;
            epc_q      <= '0;
            irq_prev_q <= '0;
            redirect_q <= 1'b0;
            busy_q     <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            im_q       <= im_d;
            ip_q       <= ip_d;
            exc_q      <= exc_d;
            epc_q      <= epc_d;
            irq_prev_q <= bus.in_irq;
            redirect_q <= redirect_d;
            busy_q     <= busy_d;
            target_q   <= target_d;
        end
    end

    assign bus.out_redirect = redirect_q;
    assign bus.out_busy     = busy_q;
    assign bus.out_target   = target_q;
    assign bus.out_status   = status_w;
    assign bus.out_cause    = cause_w;
    assign bus.out_epc      = epc_q;
endmodule

// File: tb/tb_cp0_exception_unit.sv
// Self-checking bench for cp0_exception_unit: directed vector table, corner sequences, random vs model.
module tb_cp0_exception_unit;
    localparam logic [31:0] HANDLER = 32'h0000_0800;
    localparam int          NIRQ    = 3;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        sc;
        logic        er;
        logic        rd;
        logic        wr;
        logic [4:0]  sel;
        logic [31:0] wdata;
        logic [2:0]  irq;
        logic [31:0] x_rdata;
        logic        x_redir;
        logic [31:0] x_target;
        logic [31:0] x_status;
        logic [31:0] x_cause;
        logic [31:0] x_epc;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cp0_exception_unit_if #(.NIRQ(NIRQ)) bus ();

    cp0_exception_unit #(.HANDLER_ADDR(HANDLER), .NIRQ(NIRQ)) dut (
        .in_clk  (clk),
        .in_rst_n(rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state kept as architectural 32-bit register words.
    logic [31:0] m_status, m_cause, m_epc, m_target;
    logic        m_redirect;
    logic [2:0]  m_prev;

    vec_t tab[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic sc,
                                input logic er, input logic rd, input logic wr,
                                input logic [4:0] sel, input logic [31:0] wdata,
                                input logic [2:0] irq);
        vec_t v;
        v.valid = valid; v.pc = pc; v.sc = sc; v.er = er; v.rd = rd; v.wr = wr;
        v.sel = sel; v.wdata = wdata; v.irq = irq;
        v.x_rdata = '0; v.x_redir = 1'b0; v.x_target = '0;
        v.x_status = '0; v.x_cause = '0; v.x_epc = '0;
        return v;
    endfunction

    task automatic addrow(input vec_t v, input logic [31:0] rdata, input logic redir,
                          input logic [31:0] target, input logic [31:0] status,
                          input logic [31:0] cause, input logic [31:0] epc);
        vec_t r;
        r = v;
        r.x_rdata = rdata; r.x_redir = redir; r.x_target = target;
        r.x_status = status; r.x_cause = cause; r.x_epc = epc;
        tab.push_back(r);
    endtask

    function automatic logic [31:0] m_read(input logic rd, input logic [4:0] sel);
        if (!rd) return 32'h0;
        case (sel)
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input vec_t v, input logic rst);
        logic [31:0] st0, ca0, ep0, tgt;
        logic [2:0]  rise, pend;
        logic        fire, done;
        if (!rst) begin
            m_status = 0; m_cause = 0; m_epc = 0; m_target = 0;
            m_redirect = 0; m_prev = 0;
        end else begin
            rise = v.irq & ~m_prev;
            st0 = m_status; ca0 = m_cause; ep0 = m_epc;
            pend = ca0[10:8] & st0[10:8];
            fire = 0; tgt = 0;
            if (!m_redirect && v.valid) begin
                if (v.wr) begin
                    case (v.sel)
                        5'd12:   m_status = v.wdata & 32'h0000_0701;
                        5'd13:   m_cause  = (m_cause & ~32'h0000_0700) | (v.wdata & 32'h0000_0700);
                        5'd14:   m_epc    = v.wdata;
                        default: ;
                    endcase
                end
                if (v.sc) begin
                    m_epc = v.pc;
                    m_cause = (m_cause & ~32'h0000_007C) | (32'd8 << 2);
                    m_status[0] = 1'b0;
                    fire = 1; tgt = HANDLER;
                end else if (v.er) begin
                    m_status[0] = 1'b1;
                    fire = 1; tgt = ep0;
                end else if (st0[0] && pend != 0 && !v.wr) begin
                    m_epc = v.pc + 32'd4;
                    m_cause = m_cause & ~32'h0000_007C;
                    m_status[0] = 1'b0;
                    done = 0;
                    for (int k = 0; k < 3; k++) begin
                        if (pend[k] && !done) begin
                            m_cause[8+k] = 1'b0;
                            done = 1;
                        end
                    end
                    fire = 1; tgt = HANDLER;
                end
            end
            m_cause = m_cause | ({29'd0, rise} << 8);
            m_prev = v.irq;
            m_redirect = fire;
            if (fire) m_target = tgt;
        end
    endtask

    task automatic run(input vec_t v, input logic rst, input logic use_tab);
        rst_n          = rst;
        bus.in_valid   = v.valid;
        bus.in_pc      = v.pc;
        bus.in_syscall = v.sc;
        bus.in_eret    = v.er;
        bus.in_cp0     = v.rd;
        bus.in_cpw     = v.wr;
        bus.in_sel     = v.sel;
        bus.in_wdata   = v.wdata;
        bus.in_irq     = v.irq;
        #1;
        check32("rdata_model", bus.out_rdata, m_read(v.rd, v.sel));
        if (use_tab) check32("rdata_table", bus.out_rdata, v.x_rdata);
        @(posedge clk);
        model_edge(v, rst);
        @(negedge clk);
        check32("status_model", bus.out_status, m_status);
        check32("cause_model", bus.out_cause, m_cause);
        check32("epc_model", bus.out_epc, m_epc);
        check32("redirect_model", {31'd0, bus.out_redirect}, {31'd0, m_redirect});
        check32("busy_model", {31'd0, bus.out_busy}, {31'd0, m_redirect});
        check32("target_model", bus.out_target, m_target);
        if (use_tab) begin
            check32("status_table", bus.out_status, v.x_status);
            check32("cause_table", bus.out_cause, v.x_cause);
            check32("epc_table", bus.out_epc, v.x_epc);
            check32("redirect_table", {31'd0, bus.out_redirect}, {31'd0, v.x_redir});
            check32("busy_table", {31'd0, bus.out_busy}, {31'd0, v.x_redir});
            check32("target_table", bus.out_target, v.x_target);
        end
    endtask

    function automatic vec_t idle(input logic [2:0] irq);
        return mk(0, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0, irq);
    endfunction

    initial begin
        vec_t v;
        int   kind;
        logic [2:0]  irq_r;
        logic [4:0]  sel_r;

        m_status = 0; m_cause = 0; m_epc = 0; m_target = 0; m_redirect = 0; m_prev = 0;
        @(negedge clk);

        // Reset held for two cycles with IRQ lines toggling.
        run(idle(3'b101), 1'b0, 1'b0);
        run(idle(3'b010), 1'b0, 1'b0);
        check32("rst_status", bus.out_status, 32'h0);
        check32("rst_cause", bus.out_cause, 32'h0);
        check32("rst_epc", bus.out_epc, 32'h0);
        check32("rst_redirect", {31'd0, bus.out_redirect}, 32'h0);
        check32("rst_busy", {31'd0, bus.out_busy}, 32'h0);
        run(idle(3'b000), 1'b1, 1'b0);

        addrow(mk(1, 32'h0,   0,0,0,1, 5'd12, 32'h0000_0301, 3'b000), 32'h0,         0, 32'h0,   32'h301, 32'h0,   32'h0);
        addrow(mk(1, 32'h4,   0,0,1,0, 5'd12, 32'h0,         3'b000), 32'h301,       0, 32'h0,   32'h301, 32'h0,   32'h0);
        addrow(mk(1, 32'h8,   0,0,0,1, 5'd14, 32'h1234_5678, 3'b000), 32'h0,         0, 32'h0,   32'h301, 32'h0,   32'h1234_5678);
        addrow(mk(1, 32'hC,   0,0,1,0, 5'd14, 32'h0,         3'b000), 32'h1234_5678, 0, 32'h0,   32'h301, 32'h0,   32'h1234_5678);
        addrow(mk(1, 32'h10,  0,0,1,0, 5'd5,  32'h0,         3'b000), 32'h0,         0, 32'h0,   32'h301, 32'h0,   32'h1234_5678);
        addrow(mk(1, 32'h40,  1,0,0,0, 5'd0,  32'h0,         3'b000), 32'h0,         1, 32'h800, 32'h300, 32'h20,  32'h40);
        addrow(idle(3'b000),                                           32'h0,         0, 32'h800, 32'h300, 32'h20,  32'h40);
        addrow(mk(1, 32'h800, 0,0,0,1, 5'd12, 32'h0000_0701, 3'b000), 32'h0,         0, 32'h800, 32'h701, 32'h20,  32'h40);
        addrow(idle(3'b110),                                           32'h0,         0, 32'h800, 32'h701, 32'h620, 32'h40);
        addrow(mk(1, 32'h100, 0,0,0,0, 5'd0,  32'h0,         3'b110), 32'h0,         1, 32'h800, 32'h700, 32'h400, 32'h104);
        addrow(idle(3'b110),                                           32'h0,         0, 32'h800, 32'h700, 32'h400, 32'h104);
        addrow(idle(3'b000),                                           32'h0,         0, 32'h800, 32'h700, 32'h400, 32'h104);
        addrow(idle(3'b001),                                           32'h0,         0, 32'h800, 32'h700, 32'h500, 32'h104);
        addrow(mk(1, 32'h804, 0,0,0,1, 5'd13, 32'h0000_0400, 3'b001), 32'h0,         0, 32'h800, 32'h700, 32'h400, 32'h104);
        addrow(mk(1, 32'h808, 0,1,0,0, 5'd0,  32'h0,         3'b001), 32'h0,         1, 32'h104, 32'h701, 32'h400, 32'h104);
        addrow(idle(3'b001),                                           32'h0,         0, 32'h104, 32'h701, 32'h400, 32'h104);
        addrow(mk(1, 32'h300, 0,0,0,0, 5'd0,  32'h0,         3'b001), 32'h0,         1, 32'h800, 32'h700, 32'h0,   32'h304);
        addrow(idle(3'b001),                                           32'h0,         0, 32'h800, 32'h700, 32'h0,   32'h304);
        for (int i = 0; i < tab.size(); i++) run(tab[i], 1'b1, 1'b1);

        // Reset asserted while the handler redirect is in flight.
        run(mk(1, 32'h44, 1,0,0,0, 5'd0, 32'h0, 3'b000), 1'b1, 1'b0);
        check32("enter_redirect", {31'd0, bus.out_redirect}, 32'h1);
        run(idle(3'b000), 1'b0, 1'b0);
        check32("midrst_redirect", {31'd0, bus.out_redirect}, 32'h0);
        check32("midrst_busy", {31'd0, bus.out_busy}, 32'h0);
        check32("midrst_epc", bus.out_epc, 32'h0);
        check32("midrst_target", bus.out_target, 32'h0);
        run(idle(3'b000), 1'b1, 1'b0);

        // Syscall wins over a pending interrupt and leaves IP untouched.
        run(mk(1, 32'h8, 0,0,0,1, 5'd12, 32'h0000_0701, 3'b000), 1'b1, 1'b0);
        run(idle(3'b001), 1'b1, 1'b0);
        run(mk(1, 32'h500, 1,0,0,0, 5'd0, 32'h0, 3'b001), 1'b1, 1'b0);
        check32("sc_int_cause", bus.out_cause, 32'h120);
        check32("sc_int_epc", bus.out_epc, 32'h500);
        run(idle(3'b000), 1'b1, 1'b0);

        // Software clear of IP[0] on the same edge as a new IRQ[0] rise.
        run(mk(1, 32'h20, 0,0,0,1, 5'd13, 32'h0, 3'b001), 1'b1, 1'b0);
        check32("clr_vs_rise_cause", bus.out_cause, 32'h120);

        // An mtc0 retiring with an interrupt pending does not take it.
        run(mk(1, 32'h24, 0,0,0,1, 5'd12, 32'h0000_0701, 3'b001), 1'b1, 1'b0);
        run(mk(1, 32'h28, 0,0,0,1, 5'd14, 32'h0000_0ABC, 3'b001), 1'b1, 1'b0);
        check32("mtc0_int_redirect", {31'd0, bus.out_redirect}, 32'h0);
        check32("mtc0_int_epc", bus.out_epc, 32'hABC);
        run(mk(1, 32'h600, 0,0,0,0, 5'd0, 32'h0, 3'b001), 1'b1, 1'b0);
        check32("int_after_mtc0_redirect", {31'd0, bus.out_redirect}, 32'h1);
        check32("int_after_mtc0_epc", bus.out_epc, 32'h604);
        check32("int_after_mtc0_cause", bus.out_cause, 32'h0);
        run(idle(3'b001), 1'b1, 1'b0);

        irq_r = 3'b000;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) irq_r = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       sel_r = 5'd12;
                1:       sel_r = 5'd13;
                2:       sel_r = 5'd14;
                default: sel_r = 5'($urandom_range(0, 31));
            endcase
            kind = $urandom_range(0, 6);
            v = mk(($urandom_range(0, 4) != 0), {$urandom} & 32'hFFFF_FFFC,
                   (kind == 1), (kind == 2), ($urandom_range(0, 1) == 1), (kind == 3 || kind == 4),
                   sel_r, $urandom, irq_r);
            run(v, ($urandom_range(0, 99) != 0), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
- Coprocessor-0 responder for the single-cycle MIPS core; consumes the syscall, eret, mfc0 and mtc0 strobes produced by the instruction control decoder.
- Holds the Status, Cause and EPC registers and latches external interrupt requests.
- Sequences exception entry and return, and drives a PC-redirect request to the fetch stage.

Parameters:
- HANDLER_ADDR, 32'h0000_0800, exception/interrupt handler entry PC
- NIRQ, 3, number of external interrupt lines (1..8)

Ports:
- in_clk  in  1  clock
- in_rst_n  in  1  synchronous active-low reset
- in_valid  in  1  instruction at in_pc retires this cycle
- in_pc  in  32  PC of the retiring instruction
- in_syscall  in  1  syscall strobe from the decoder
- in_eret  in  1  eret strobe from the decoder
- in_cp0  in  1  mfc0 read strobe
- in_cpw  in  1  mtc0 write strobe
- in_sel  in  5  CP0 register number (rd field)
- in_wdata  in  32  mtc0 write data (rt value)
- in_irq  in  NIRQ  external interrupt levels, synchronous to in_clk
- out_rdata  out  32  mfc0 read data
- out_redirect  out  1  one-cycle PC-load request
- out_target  out  32  PC to load when out_redirect=1
- out_busy  out  1  CPU must stall (hold in_valid low)
- out_status  out  32  Status register
- out_cause  out  32  Cause register
- out_epc  out  32  EPC register

Behaviour:
- Reset, sampled on the in_clk rising edge while in_rst_n=0:
  - Status, Cause, EPC and out_target = 0.
  - out_redirect and out_busy = 0.
  - FSM state = IDLE.
  - IRQ edge-history register = 0.
  - Reset overrides any in-flight state.
- Registers:
  - Status (sel 12): bit0 IE; bits[8+NIRQ-1:8] IM; all other bits read 0.
  - Cause (sel 13): bits[6:2] ExcCode; bits[8+NIRQ-1:8] IP; all other bits read 0.
  - EPC (sel 14): all 32 bits.
- mfc0 read is combinational: out_rdata = selected register. Any other sel, or in_cp0=0, gives 0.
- mtc0 write, when in_cpw & in_valid, updates at the clock edge:
  - sel 12: IE and IM.
  - sel 13: IP only (software clear or set).
  - sel 14: EPC.
  - Any other sel is ignored.
- IRQ capture:
  - A rising edge on in_irq[i] sets IP[i], in any FSM state.
  - If a capture coincides with an mtc0 clear of IP[i], the set wins.
- Interrupt pending: int_req = IE & |(IP & IM).
- FSM states: IDLE, ENTER, RETURN.
- IDLE transitions, highest priority first:
  - in_valid & in_syscall:
    - EPC <= in_pc, ExcCode <= 8, IE <= 0; go to ENTER.
  - in_valid & in_eret:
    - IE <= 1; go to RETURN.
  - in_valid & int_req & !in_cpw:
    - EPC <= in_pc+4 (mod 2^32), ExcCode <= 0, IE <= 0.
    - Clear IP[k] for the lowest k with IP[k]&IM[k].
    - Go to ENTER.
  - Otherwise stay in IDLE.
- ENTER (one cycle): out_redirect=1, out_target=HANDLER_ADDR, out_busy=1; next state IDLE.
- RETURN (one cycle): out_redirect=1, out_target=EPC, out_busy=1; next state IDLE.
- out_redirect, out_target and out_busy are registered outputs. Latency from the triggering edge to redirect is 1 cycle.
- Strobes arriving while not in IDLE are ignored; the CPU is stalled then. IRQ edges are still captured.
- Nesting is blocked because IE=0 after entry. Software re-enables IE via eret or mtc0.
- out_target holds its last value when out_redirect=0.

Test Plan:
- Reset: hold in_rst_n=0 for 2 cycles with in_irq toggling -> Status=Cause=EPC=0, out_redirect=0, out_busy=0; in_rst_n=0 mid-ENTER -> next cycle IDLE, outputs 0.
- mtc0/mfc0 sequence:
  - mtc0 sel12 = 32'h0000_0301 -> mfc0 sel12 reads 32'h0000_0301 (NIRQ=3).
  - mtc0 sel14 = 32'h1234_5678 -> mfc0 sel14 reads 32'h1234_5678.
  - mfc0 sel 5 reads 0.
- Syscall at in_pc=32'h0000_0040 -> next cycle out_redirect=1, out_target=32'h0000_0800, out_busy=1; EPC=32'h40, ExcCode=8, IE=0; the cycle after, out_redirect=0.
- Interrupt: Status=32'h0000_0701, in_irq=3'b110 rises, retire in_pc=32'h0000_0100 -> EPC=32'h104, IP=3'b100 (bit1 cleared), ExcCode=0, redirect to 32'h800. With IE=0, irq edges set IP but cause no redirect.
- eret with EPC=32'h0000_0104 -> next cycle out_redirect=1, out_target=32'h104, IE=1; pending IP[2]&IM[2] is then taken on the next retiring instruction.
- Simultaneous events:
  - syscall and int_req in the same cycle -> ExcCode=8; IP unchanged.
  - mtc0 clearing IP[0] on the same edge as an in_irq[0] rise -> IP[0]=1.
  - mtc0 with int_req -> no entry that cycle.
